// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode map, PSR bit positions and
// the multiplier sequencing states.
package alu_pkg;

   localparam logic [7:0] OP_AND   = 8'h01;
   localparam logic [7:0] OP_OR    = 8'h02;
   localparam logic [7:0] OP_XOR   = 8'h03;
   localparam logic [7:0] OP_ADD   = 8'h05;
   localparam logic [7:0] OP_ADDU  = 8'h06;
   localparam logic [7:0] OP_SUB   = 8'h09;
   localparam logic [7:0] OP_CMP   = 8'h0B;
   localparam logic [7:0] OP_MOV   = 8'h0D;
   localparam logic [7:0] OP_MUL   = 8'h0E;
   localparam logic [7:0] OP_SHL1  = 8'h80;
   localparam logic [7:0] OP_SHR1  = 8'h81;
   localparam logic [7:0] OP_ASHR1 = 8'h83;
   localparam logic [7:0] OP_LSH   = 8'h84;
   // LUI occupies the whole 0xF0..0xFF block; only the upper nibble decodes.
   localparam logic [3:0] OP_LUI_HI = 4'hF;

   // PSR layout {N,Z,F,L,C}
   localparam int PSR_C = 0;
   localparam int PSR_L = 1;
   localparam int PSR_F = 2;
   localparam int PSR_Z = 3;
   localparam int PSR_N = 4;
   localparam int PSR_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   function automatic logic is_lui(input logic [7:0] op);
      return (op[7:4] == OP_LUI_HI);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// i_start loads the operands; o_done is high during the final step, and
// o_product carries the finished low WIDTH bits from that step onwards
// until the next start.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             r_busy;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_acc_next;

   // Only the low WIDTH bits are kept, so the shifted multiplicand may drop
   // its top bits without affecting the result.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_done     = r_busy & (r_count == LAST);
   assign o_product  = r_busy ? w_acc_next : r_acc;

   // Operand load on start, then one shift-add step per cycle for WIDTH cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_count  <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_count  <= '0;
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + 1'b1;
         if (r_count == LAST) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU stage between register-file read and writeback.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until ready is
// seen, and ready may depend combinationally on the downstream ready.
// Single-cycle ops land in the output register on the accepting edge; MUL
// runs through the iterative multiplier and blocks issue until it lands.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       opcode,
   input  logic [WIDTH-1:0] rdata_a,
   input  logic [WIDTH-1:0] rdata_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       psr_out,
   output logic             out_illegal
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int HALF = WIDTH / 2;

   mul_state_t       r_state;
   logic [WIDTH-1:0] r_result;
   logic [PSR_W-1:0] r_psr;
   logic             r_illegal;
   logic             r_out_valid;

   logic             w_slot_free;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_start;
   logic             w_load_exec;
   logic             w_load_mul;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_res;
   logic [PSR_W-1:0] w_psr;
   logic             w_ill;

   // The output slot can take new data when empty or being drained this cycle.
   assign w_slot_free = !r_out_valid | out_ready;
   assign in_ready    = (r_state == ST_IDLE) & w_slot_free;
   assign w_accept    = in_valid & in_ready;
   assign w_is_mul    = MUL_EN & (opcode == OP_MUL);
   assign w_mul_start = w_accept & w_is_mul;
   assign w_load_exec = w_accept & !w_is_mul;
   assign w_load_mul  = ((r_state == ST_BUSY) & w_mul_done | (r_state == ST_DONE))
                        & w_slot_free;

   assign w_sum   = {1'b0, rdata_a} + {1'b0, rdata_b};
   assign w_diff  = {1'b0, rdata_a} - {1'b0, rdata_b};
   assign w_shamt = rdata_b[SHW-1:0];

   assign out_valid   = r_out_valid;
   assign result      = r_result;
   assign psr_out     = r_psr;
   assign out_illegal = r_illegal;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clock     (clock),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_a       (rdata_a),
      .i_b       (rdata_b),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // Single-cycle decode/execute; flags not touched by an op pass through.
   always_comb begin
      w_res = '0;
      w_psr = r_psr;
      w_ill = 1'b0;
      if (is_lui(opcode)) begin
         w_res = {rdata_b[HALF-1:0], {HALF{1'b0}}};
      end else begin
         case (opcode)
            OP_AND: w_res = rdata_a & rdata_b;
            OP_OR:  w_res = rdata_a | rdata_b;
            OP_XOR: w_res = rdata_a ^ rdata_b;
            OP_ADD: begin
               w_res        = w_sum[WIDTH-1:0];
               w_psr[PSR_C] = w_sum[WIDTH];
               w_psr[PSR_F] = (rdata_a[WIDTH-1] == rdata_b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != rdata_a[WIDTH-1]);
            end
            OP_ADDU: begin
               w_res        = w_sum[WIDTH-1:0];
               w_psr[PSR_C] = w_sum[WIDTH];
            end
            OP_SUB: begin
               w_res        = w_diff[WIDTH-1:0];
               w_psr[PSR_C] = w_diff[WIDTH];
               w_psr[PSR_F] = (rdata_a[WIDTH-1] != rdata_b[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != rdata_a[WIDTH-1]);
            end
            OP_CMP: begin
               w_psr[PSR_Z] = (rdata_a == rdata_b);
               w_psr[PSR_L] = (rdata_b > rdata_a);
               w_psr[PSR_N] = ($signed(rdata_b) > $signed(rdata_a));
            end
            OP_MOV: w_res = rdata_b;
            // Reaches here only when the multiplier is configured out.
            OP_MUL: w_ill = !MUL_EN;
            OP_LSH: w_res = rdata_a << w_shamt;
            OP_SHL1: begin
               w_res        = {rdata_a[WIDTH-2:0], 1'b0};
               w_psr[PSR_C] = rdata_a[WIDTH-1];
            end
            OP_SHR1: begin
               w_res        = {1'b0, rdata_a[WIDTH-1:1]};
               w_psr[PSR_C] = rdata_a[0];
            end
            OP_ASHR1: begin
               w_res        = {rdata_a[WIDTH-1], rdata_a[WIDTH-1:1]};
               w_psr[PSR_C] = rdata_a[0];
            end
            default: w_ill = 1'b1;
         endcase
      end
   end

   // Output register: load from execute or multiplier, otherwise hold until drained
   always_ff @(posedge clock) begin
      if (reset) begin
         r_result    <= '0;
         r_psr       <= '0;
         r_illegal   <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_load_exec) begin
         r_result    <= w_res;
         r_psr       <= w_psr;
         r_illegal   <= w_ill;
         r_out_valid <= 1'b1;
      end else if (w_load_mul) begin
         r_result    <= w_mul_product;
         r_illegal   <= 1'b0;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // MUL sequencing: issue is blocked from start until the product is loaded
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_mul_start) r_state <= ST_BUSY;
            ST_BUSY: if (w_mul_done) r_state <= w_slot_free ? ST_IDLE : ST_DONE;
            ST_DONE: if (w_slot_free) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: vector table replayed with and without backpressure,
// plus hand sequences for latency, MUL, output hold and reset abort.
module tb_alu_pipe;

   localparam int W  = 16;
   localparam int EW = 1 + 5 + W;   // {illegal, psr, result}

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    opcode;
   logic [W-1:0]  rdata_a;
   logic [W-1:0]  rdata_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic [4:0]    psr_out;
   logic          out_illegal;

   typedef struct {
      logic [7:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [4:0]   psr;
      logic         ill;
   } vec_t;

   vec_t           tv[$];
   logic [EW-1:0]  exp_q[$];
   logic [EW-1:0]  drv_exp;
   int             errors;
   int             checks;
   int             cyc;
   bit             bp_en;

   alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .rdata_a     (rdata_a),
      .rdata_b     (rdata_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .psr_out     (psr_out),
      .out_illegal (out_illegal)
   );

   // clock / cycle counter
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // scoreboard: push on accept, pop/compare on output transfer
   task automatic monitor();
      logic [EW-1:0] e;
      logic [EW-1:0] g;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (out_valid && out_ready) begin
               checks++;
               g = {out_illegal, psr_out, result};
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL out_unexpected: got ill=%0b psr=%h res=%h with empty queue",
                           out_illegal, psr_out, result);
               end else begin
                  e = exp_q.pop_front();
                  if (g !== e) begin
                     errors++;
                     $display("FAIL out_data: got ill=%0b psr=%h res=%h want ill=%0b psr=%h res=%h",
                              g[EW-1], g[EW-2:W], g[W-1:0], e[EW-1], e[EW-2:W], e[W-1:0]);
                  end
               end
            end
            if (in_valid && in_ready) exp_q.push_back(drv_exp);
         end
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   // driver: present one op and hold it until accepted (bounded)
   task automatic send(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EW-1:0] exp);
      int   n;
      logic acc;
      n        = 0;
      acc      = 1'b0;
      opcode   = op;
      rdata_a  = a;
      rdata_b  = b;
      drv_exp  = exp;
      in_valid = 1'b1;
      while (!acc && n < 200) begin
         if (bp_en) out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 32'(n), 32'(0));
   endtask

   task automatic run_table();
      foreach (tv[i]) send(tv[i].op, tv[i].a, tv[i].b, {tv[i].ill, tv[i].psr, tv[i].res});
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      check({tag, "_result"}, 32'(result), 32'(0));
      check({tag, "_psr"}, 32'(psr_out), 32'(0));
      check({tag, "_illegal"}, 32'(out_illegal), 32'(0));
      check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
   endtask

   initial begin
      int start_cyc;
      int rise;
      bit saw_ready;
      bit seen;
      errors    = 0;
      checks    = 0;
      cyc       = 0;
      bp_en     = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      opcode    = 8'h00;
      rdata_a   = '0;
      rdata_b   = '0;
      out_ready = 1'b1;
      drv_exp   = '0;

      //                 op     A        B        result   psr    ill
      tv.push_back('{8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'h04, 1'b0});
      tv.push_back('{8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'h01, 1'b0});
      tv.push_back('{8'h0B, 16'h0005, 16'h0005, 16'h0000, 5'h09, 1'b0});
      tv.push_back('{8'h0B, 16'hFFFF, 16'h0001, 16'h0000, 5'h11, 1'b0});
      tv.push_back('{8'h01, 16'hF0F0, 16'hFF00, 16'hF000, 5'h11, 1'b0});
      tv.push_back('{8'h02, 16'hF0F0, 16'h0F0F, 16'hFFFF, 5'h11, 1'b0});
      tv.push_back('{8'h03, 16'hAAAA, 16'hFFFF, 16'h5555, 5'h11, 1'b0});
      tv.push_back('{8'h06, 16'h0001, 16'h0001, 16'h0002, 5'h10, 1'b0});
      tv.push_back('{8'h06, 16'hFFFF, 16'h0002, 16'h0001, 5'h11, 1'b0});
      tv.push_back('{8'h05, 16'h8000, 16'h8000, 16'h0000, 5'h15, 1'b0});
      tv.push_back('{8'h06, 16'h7FFF, 16'h0001, 16'h8000, 5'h14, 1'b0});
      tv.push_back('{8'h09, 16'h8000, 16'h0001, 16'h7FFF, 5'h14, 1'b0});
      tv.push_back('{8'h09, 16'h0001, 16'h0002, 16'hFFFF, 5'h11, 1'b0});
      tv.push_back('{8'h0B, 16'h0003, 16'h0007, 16'h0000, 5'h13, 1'b0});
      tv.push_back('{8'h0B, 16'h0007, 16'h8000, 16'h0000, 5'h03, 1'b0});
      tv.push_back('{8'h0D, 16'h1234, 16'hABCD, 16'hABCD, 5'h03, 1'b0});
      tv.push_back('{8'h84, 16'h0001, 16'h000F, 16'h8000, 5'h03, 1'b0});
      tv.push_back('{8'h84, 16'h00FF, 16'h0014, 16'h0FF0, 5'h03, 1'b0});
      tv.push_back('{8'h80, 16'h8001, 16'h0000, 16'h0002, 5'h03, 1'b0});
      tv.push_back('{8'h81, 16'h8002, 16'h0000, 16'h4001, 5'h02, 1'b0});
      tv.push_back('{8'h83, 16'h8003, 16'h0000, 16'hC001, 5'h03, 1'b0});
      tv.push_back('{8'hF3, 16'h5555, 16'h12AB, 16'hAB00, 5'h03, 1'b0});
      tv.push_back('{8'hF0, 16'h0000, 16'h00FF, 16'hFF00, 5'h03, 1'b0});
      tv.push_back('{8'h07, 16'h1111, 16'h2222, 16'h0000, 5'h03, 1'b1});
      tv.push_back('{8'h00, 16'h1111, 16'h2222, 16'h0000, 5'h03, 1'b1});
      tv.push_back('{8'h05, 16'h0001, 16'h0001, 16'h0002, 5'h02, 1'b0});
      tv.push_back('{8'h09, 16'h0005, 16'h0005, 16'h0000, 5'h02, 1'b0});

      fork
         monitor();
      join_none

      // reset state
      do_reset();
      check_reset_state("rst0");

      // single-cycle latency: valid right after the accepting edge
      send(8'h05, 16'h7FFF, 16'h0001, {1'b0, 5'h04, 16'h8000});
      check("add_latency_valid", 32'(out_valid), 32'(1));
      drain();

      // table, full throughput
      do_reset();
      run_table();
      drain();

      // reset after activity
      do_reset();
      check_reset_state("rst1");

      // table with random backpressure
      bp_en = 1'b1;
      run_table();
      bp_en = 1'b0;
      drain();

      // MUL latency and issue blocking
      do_reset();
      send(8'h0E, 16'h0012, 16'h0034, {1'b0, 5'h00, 16'h03A8});
      rise      = 0;
      saw_ready = 1'b0;
      for (int e = 1; e <= 3 * W; e++) begin
         if (out_valid) begin
            rise = e;
            break;
         end
         if (in_ready) saw_ready = 1'b1;
         @(posedge clock);
         #1;
      end
      check("mul_latency_edges", 32'(rise), 32'(W + 1));
      check("mul_in_ready_low", 32'(saw_ready), 32'(0));
      drain();

      // MUL result held under backpressure
      out_ready = 1'b0;
      send(8'h0E, 16'hFFFF, 16'hFFFF, {1'b0, 5'h00, 16'h0001});
      repeat (W + 3) begin
         @(posedge clock);
         #1;
      end
      check("mul_hold_valid", 32'(out_valid), 32'(1));
      check("mul_hold_result", 32'(result), 32'h0001);
      check("mul_hold_in_ready", 32'(in_ready), 32'(0));
      out_ready = 1'b1;
      @(posedge clock);
      #1;

      // XOR held for 4 cycles, then released into back-to-back issue
      out_ready = 1'b0;
      send(8'h03, 16'h00FF, 16'h0F0F, {1'b0, 5'h00, 16'h0FF0});
      for (int k = 0; k < 4; k++) begin
         check("hold_valid", 32'(out_valid), 32'(1));
         check("hold_result", 32'(result), 32'h0FF0);
         check("hold_in_ready", 32'(in_ready), 32'(0));
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      start_cyc = cyc;
      send(8'h05, 16'h0001, 16'h0002, {1'b0, 5'h00, 16'h0003});
      check("b2b_valid_0", 32'(out_valid), 32'(1));
      send(8'h0D, 16'h0000, 16'h5A5A, {1'b0, 5'h00, 16'h5A5A});
      check("b2b_valid_1", 32'(out_valid), 32'(1));
      send(8'h02, 16'h0F00, 16'h00F0, {1'b0, 5'h00, 16'h0FF0});
      check("b2b_valid_2", 32'(out_valid), 32'(1));
      check("b2b_cycles", 32'(cyc - start_cyc), 32'(3));
      drain();

      // reset in the middle of a MUL aborts it
      send(8'h0E, 16'h0003, 16'h0004, {1'b0, 5'h00, 16'h000C});
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      reset = 1'b1;
      exp_q.delete();
      @(posedge clock);
      #1 reset = 1'b0;
      check_reset_state("rst_mul");
      seen = 1'b0;
      repeat (2 * W) begin
         if (out_valid) seen = 1'b1;
         @(posedge clock);
         #1;
      end
      check("rst_mul_no_output", 32'(seen), 32'(0));
      check("rst_mul_idle", 32'(in_ready), 32'(1));
      check("final_queue_empty", 32'(exp_q.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // global time limit
   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
